// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 16x oversampling,
// 3-sample majority vote, runtime parity/stop configuration and an
// output FIFO carrying per-frame error flags.
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous reset, active low
//   rx_i           asynchronous serial input, idle high
//   baud_div_i     clk cycles per sample tick (0 behaves as 1)
//   parity_mode_i  00 none, 01 even, 10 odd, 11 none
//   two_stop_i     1 = two stop bits expected
//   rx_data_o      FIFO head data, right-aligned (0 when empty)
//   rx_valid_o     FIFO non-empty
//   rx_ack_i       pops head when rx_valid_o=1
//   parity_err_o   head entry parity mismatch
//   frame_err_o    head entry had a stop bit sampled low
//   overrun_o      sticky, a frame was dropped because the FIFO was full
//   err_clr_i      clears overrun_o
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    input  logic [DIV_W-1:0]     baud_div_i,
    input  logic [1:0]           parity_mode_i,
    input  logic                 two_stop_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ack_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    input  logic                 err_clr_i
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int EW   = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH
    } state_e;

    state_e               state_q;
    logic                 rx_s1_q, rxs_q;
    logic [DIV_W-1:0]     div_cnt_q, div_lat_q;
    logic [OS_W-1:0]      os_cnt_q;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [1:0]           samp_q;
    logic                 bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 perr_q, ferr_q;
    logic [1:0]           par_lat_q;
    logic                 two_lat_q;

    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q;
    logic [PW:0]                   wr_ptr_q, rd_ptr_q;
    logic                          overrun_q;

    // Bit timing
    logic [DIV_W-1:0] div_eff;
    logic             active, tick, smp_a, smp_b, smp_c, bit_end, maj, par_en;

    assign div_eff = (div_lat_q == '0) ? DIV_W'(1) : div_lat_q;
    assign active  = (state_q != S_IDLE) && (state_q != S_PUSH);
    assign tick    = active && (div_cnt_q == div_eff - DIV_W'(1));
    assign smp_a   = tick && (os_cnt_q == OS_W'(OVERSAMPLE/2 - 1));
    assign smp_b   = tick && (os_cnt_q == OS_W'(OVERSAMPLE/2));
    assign smp_c   = tick && (os_cnt_q == OS_W'(OVERSAMPLE/2 + 1));
    assign bit_end = tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
    // Third sample is taken live from rxs_q, the first two were stored.
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign par_en  = (par_lat_q == 2'b01) || (par_lat_q == 2'b10);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            rx_s1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            div_cnt_q <= '0;
            div_lat_q <= '0;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '0;
            bit_q     <= 1'b1;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            par_lat_q <= '0;
            two_lat_q <= 1'b0;
        end else begin
            rx_s1_q <= rx_i;
            rxs_q   <= rx_s1_q;

            if (active) begin
                div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick)
                    os_cnt_q <= bit_end ? '0 : os_cnt_q + OS_W'(1);
            end
            if (smp_a) samp_q[0] <= rxs_q;
            if (smp_b) samp_q[1] <= rxs_q;
            if (smp_c) bit_q     <= maj;

            case (state_q)
                S_IDLE: begin
                    div_cnt_q <= '0;
                    os_cnt_q  <= '0;
                    if (!rxs_q) begin
                        // Configuration is frozen for the whole frame.
                        div_lat_q <= baud_div_i;
                        par_lat_q <= parity_mode_i;
                        two_lat_q <= two_stop_i;
                        bit_cnt_q <= '0;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    // A start bit that votes high was a glitch.
                    if (bit_end) state_q <= bit_q ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (smp_c) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en ? S_PARITY : S_STOP1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    // Even: any odd total is an error. Odd: inverted sense.
                    if (smp_c) perr_q <= (^shreg_q) ^ maj ^ (par_lat_q == 2'b10);
                    if (bit_end) state_q <= S_STOP1;
                end
                S_STOP1: begin
                    if (smp_c) begin
                        ferr_q <= ~maj;
                        // Leaving at mid-stop lets the next start bit follow with no gap.
                        if (!two_lat_q) state_q <= S_PUSH;
                    end else if (bit_end) begin
                        state_q <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (smp_c) begin
                        ferr_q  <= ferr_q | ~maj;
                        state_q <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    div_cnt_q <= '0;
                    os_cnt_q  <= '0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output FIFO
    logic          push, pop, full;
    logic [EW-1:0] head;

    assign push = (state_q == S_PUSH);
    assign pop  = rx_valid_o && rx_ack_i;
    assign full = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            // A simultaneous pop frees the slot, so a full FIFO still accepts.
            if (push && (!full || pop)) begin
                mem_q[wr_ptr_q[PW-1:0]] <= {ferr_q, perr_q, shreg_q};
                wr_ptr_q                <= wr_ptr_q + (PW+1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            if (push && full && !pop) overrun_q <= 1'b1;
            else if (err_clr_i)       overrun_q <= 1'b0;
        end
    end

    assign head         = mem_q[rd_ptr_q[PW-1:0]];
    assign rx_valid_o   = (wr_ptr_q != rd_ptr_q);
    assign rx_data_o    = rx_valid_o ? head[DATA_BITS-1:0] : '0;
    assign parity_err_o = rx_valid_o & head[DATA_BITS];
    assign frame_err_o  = rx_valid_o & head[DATA_BITS+1];
    assign overrun_o    = overrun_q;

endmodule
